// File: rtl/mvm_pkg.sv
// Shared types and default sizing for the MVM tile sequencer and its bench.
package mvm_pkg;

    localparam int VEC_LEN  = 4;
    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 8;
    localparam int W_CYCLES = 16;
    localparam int TIMEOUT  = 64;

    typedef logic [VEC_LEN-1:0][DATA_W-1:0] vec_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_EMIT   = 3'd4,
        ST_DONE   = 3'd5
    } ctl_state_e;

endpackage

// File: rtl/mvm_tile_ctl.sv
// Tile sequencer for the bit-serial MVM: per tile it clears the MVM, streams
// W_CYCLES weight words from weight RAM, waits for the MVM to go idle and hands
// the result vector downstream on a valid/ready port. All control outputs are
// registered from the next-state decode; only the weight word is a gated
// pass-through of the RAM read data.
module mvm_tile_ctl #(
    parameter int VEC_LEN  = mvm_pkg::VEC_LEN,
    parameter int DATA_W   = mvm_pkg::DATA_W,
    parameter int ADDR_W   = mvm_pkg::ADDR_W,
    parameter int W_CYCLES = mvm_pkg::W_CYCLES,
    parameter int TIMEOUT  = mvm_pkg::TIMEOUT
) (
    input  logic                        i_clk_ctl,
    input  logic                        i_rst_n_ctl,
    input  logic                        i_job_valid,
    output logic                        o_job_ready,
    input  logic [ADDR_W-1:0]           i_job_wbase,
    input  logic [3:0]                  i_job_tiles,
    output logic                        o_wmem_en,
    output logic [ADDR_W-1:0]           o_wmem_addr,
    input  logic [DATA_W-1:0]           i_wmem_data,
    output logic                        o_rst_mvm,
    output logic                        o_start_mvm,
    output logic [DATA_W-1:0]           o_w_mvm,
    input  logic                        i_ismvm,
    input  logic [VEC_LEN*DATA_W-1:0]   i_wx_result,
    output logic                        o_res_valid,
    input  logic                        i_res_ready,
    output logic [VEC_LEN*DATA_W-1:0]   o_res_data,
    output logic [3:0]                  o_res_tile,
    output logic                        o_job_done,
    output logic                        o_err
);
    import mvm_pkg::*;

    localparam int K_W = $clog2(W_CYCLES);
    localparam int C_W = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [K_W-1:0]    K_LAST   = K_W'(W_CYCLES - 1);
    localparam logic [K_W-1:0]    K_ONE    = K_W'(1);
    localparam logic [C_W-1:0]    C_LAST   = C_W'(TIMEOUT - 1);
    localparam logic [C_W-1:0]    C_MIN    = C_W'(2);
    localparam logic [C_W-1:0]    C_ONE    = C_W'(1);

    ctl_state_e          state_r, state_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [3:0]          tiles_r, tiles_s;
    logic [3:0]          tile_r, tile_s;
    logic [K_W-1:0]      k_r, k_s;
    logic [C_W-1:0]      wcnt_r, wcnt_s;
    logic                err_s;
    logic                cap_s;
    logic                w_gate_r;
    logic                job_ready_s, wmem_en_s, rst_mvm_s, start_s;
    logic                w_gate_s, res_valid_s, job_done_s;
    logic [ADDR_W-1:0]   wmem_addr_s;

    // Weight word reaches the MVM only while streaming; RAM data already lags the read by one cycle
    assign o_w_mvm = w_gate_r ? i_wmem_data : {DATA_W{1'b0}};

    // Next state, counter updates and the output values that go with the next state
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        tiles_s = tiles_r;
        tile_s  = tile_r;
        k_s     = k_r;
        wcnt_s  = wcnt_r;
        err_s   = o_err;
        cap_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_job_valid && o_job_ready) begin
                    tiles_s = i_job_tiles;
                    tile_s  = 4'd0;
                    addr_s  = i_job_wbase;
                    err_s   = 1'b0;
                    k_s     = {K_W{1'b0}};
                    wcnt_s  = {C_W{1'b0}};
                    if (i_job_tiles == 4'd0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ARM;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                addr_s  = addr_r + ADDR_ONE;
                k_s     = {K_W{1'b0}};
                state_s = ST_STREAM;
            end
            ST_STREAM: begin
                if (k_r == K_LAST) begin
                    wcnt_s  = {C_W{1'b0}};
                    state_s = ST_WAIT;
                end else begin
                    addr_s = addr_r + ADDR_ONE;
                    k_s    = k_r + K_ONE;
                end
            end
            ST_WAIT: begin
                if (!i_ismvm && (wcnt_r >= C_MIN)) begin
                    cap_s   = 1'b1;
                    state_s = ST_EMIT;
                end else if (wcnt_r == C_LAST) begin
                    err_s   = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    wcnt_s = wcnt_r + C_ONE;
                end
            end
            ST_EMIT: begin
                if (i_res_ready) begin
                    if (tile_r == (tiles_r - 4'd1)) begin
                        state_s = ST_DONE;
                    end else begin
                        tile_s  = tile_r + 4'd1;
                        state_s = ST_ARM;
                    end
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        job_ready_s = (state_s == ST_IDLE);
        rst_mvm_s   = (state_s == ST_ARM);
        wmem_en_s   = (state_s == ST_ARM) || ((state_s == ST_STREAM) && (k_s != K_LAST));
        wmem_addr_s = wmem_en_s ? addr_s : {ADDR_W{1'b0}};
        start_s     = (state_s == ST_STREAM) && (k_s == {K_W{1'b0}});
        w_gate_s    = (state_s == ST_STREAM);
        res_valid_s = (state_s == ST_EMIT);
        job_done_s  = (state_s == ST_DONE);
    end

    // State, counters, result capture and registered outputs; reset holds the MVM in reset
    always_ff @(posedge i_clk_ctl) begin
        if (!i_rst_n_ctl) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            tiles_r     <= 4'd0;
            tile_r      <= 4'd0;
            k_r         <= {K_W{1'b0}};
            wcnt_r      <= {C_W{1'b0}};
            w_gate_r    <= 1'b0;
            o_job_ready <= 1'b0;
            o_wmem_en   <= 1'b0;
            o_wmem_addr <= {ADDR_W{1'b0}};
            o_rst_mvm   <= 1'b1;
            o_start_mvm <= 1'b0;
            o_res_valid <= 1'b0;
            o_res_data  <= {(VEC_LEN*DATA_W){1'b0}};
            o_res_tile  <= 4'd0;
            o_job_done  <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            tiles_r     <= tiles_s;
            tile_r      <= tile_s;
            k_r         <= k_s;
            wcnt_r      <= wcnt_s;
            w_gate_r    <= w_gate_s;
            o_job_ready <= job_ready_s;
            o_wmem_en   <= wmem_en_s;
            o_wmem_addr <= wmem_addr_s;
            o_rst_mvm   <= rst_mvm_s;
            o_start_mvm <= start_s;
            o_res_valid <= res_valid_s;
            o_job_done  <= job_done_s;
            o_err       <= err_s;
            if (cap_s) begin
                o_res_data <= i_wx_result;
                o_res_tile <= tile_r;
            end
        end
    end

endmodule

// File: tb/tb_mvm_tile_ctl.sv
// Self-checking bench for mvm_tile_ctl: weight RAM model, MVM stub and a
// result scoreboard filled when jobs are issued and drained on each handshake.
module tb_mvm_tile_ctl;
    import mvm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, job_valid, job_ready;
    logic [7:0]  job_wbase;
    logic [3:0]  job_tiles;
    logic        wmem_en;
    logic [7:0]  wmem_addr;
    logic [3:0]  wmem_data = 4'h0;
    logic        rst_mvm, start_mvm, ismvm;
    logic [3:0]  w_mvm;
    logic [15:0] wx_result;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_tile;
    logic        job_done, err;
    logic        stuck;

    logic [3:0]  ram [256];
    vec_t        acc_v = '0;
    int          scnt = 0;
    logic        busy = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          start_cnt = 0, rst_cnt = 0, done_cnt = 0, valid_cnt = 0;
    logic [7:0]  addr_log [$];
    logic [19:0] exp_q [$];

    mvm_tile_ctl dut (
        .i_clk_ctl(clk), .i_rst_n_ctl(rst_n),
        .i_job_valid(job_valid), .o_job_ready(job_ready),
        .i_job_wbase(job_wbase), .i_job_tiles(job_tiles),
        .o_wmem_en(wmem_en), .o_wmem_addr(wmem_addr), .i_wmem_data(wmem_data),
        .o_rst_mvm(rst_mvm), .o_start_mvm(start_mvm), .o_w_mvm(w_mvm),
        .i_ismvm(ismvm), .i_wx_result(wx_result),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_tile(res_tile),
        .o_job_done(job_done), .o_err(err)
    );

    always #5 clk = ~clk;

    // One MVM accumulation step per weight word (stub behaviour, also used for expectations)
    function automatic logic [3:0] mvm_step(input logic [3:0] acc, input logic [3:0] w, input int j);
        logic [3:0] p;
        p = 4'(w * 15 + j);
        return {acc[2:0], acc[3]} ^ p;
    endfunction

    function automatic vec_t model_tile(input logic [7:0] base);
        vec_t v;
        v = '0;
        for (int k = 0; k < W_CYCLES; k++) begin
            for (int j = 0; j < VEC_LEN; j++) v[j] = mvm_step(v[j], ram[8'(base + k)], j);
        end
        return v;
    endfunction

    // Synchronous weight RAM: data one cycle after enable
    always @(posedge clk) if (wmem_en) wmem_data <= ram[wmem_addr];

    // MVM stub: accumulate W_CYCLES words from start, stay busy 3 more cycles
    always @(posedge clk) begin
        if (rst_mvm) begin
            acc_v <= '0; scnt <= 0; busy <= 1'b0;
        end else if (start_mvm || (busy && scnt < W_CYCLES)) begin
            for (int j = 0; j < VEC_LEN; j++) acc_v[j] <= mvm_step(acc_v[j], w_mvm, j);
            scnt <= scnt + 1; busy <= 1'b1;
        end else if (busy && scnt < W_CYCLES + 3) begin
            scnt <= scnt + 1;
        end else begin
            busy <= 1'b0;
        end
    end
    assign ismvm = busy | stuck;
    assign wx_result = acc_v;

    // Activity monitor on the falling edge
    always @(negedge clk) begin
        if (wmem_en) addr_log.push_back(wmem_addr);
        if (start_mvm) start_cnt <= start_cnt + 1;
        if (rst_mvm) rst_cnt <= rst_cnt + 1;
        if (job_done) done_cnt <= done_cnt + 1;
        if (res_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_job(input logic [7:0] wb, input logic [3:0] nt, input bit push);
        int n;
        job_wbase = wb; job_tiles = nt; job_valid = 1'b1;
        n = 0;
        while (job_ready !== 1'b1 && n < 50) begin step(); n++; end
        checks++;
        if (job_ready !== 1'b1) begin
            failures++; $display("FAIL job_accept: job_ready=%b required 1", job_ready);
        end
        if (push) for (int t = 0; t < int'(nt); t++) exp_q.push_back({4'(t), model_tile(8'(wb + t * W_CYCLES))});
        step();
        job_valid = 1'b0;
    endtask

    task automatic drain_results(input int nt, input int stall);
        int n;
        logic [15:0] hd;
        logic [3:0]  ht;
        logic [19:0] e;
        for (int t = 0; t < nt; t++) begin
            n = 0;
            while (res_valid !== 1'b1 && n < 300) begin step(); n++; end
            checks++;
            if (res_valid !== 1'b1) begin
                failures++; $display("FAIL res_valid_timeout: tile %0d valid=%b required 1", t, res_valid);
                return;
            end
            hd = res_data; ht = res_tile;
            for (int s = 0; s < stall; s++) begin
                step();
                checks++;
                if (res_valid !== 1'b1 || res_data !== hd || res_tile !== ht) begin
                    failures++;
                    $display("FAIL stall_stable: valid=%b data=%h tile=%0d required 1 %h %0d", res_valid, res_data, res_tile, hd, ht);
                end
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hFFFFF;
            checks++;
            if (res_data !== e[15:0]) begin
                failures++; $display("FAIL res_data: got %h required %h", res_data, e[15:0]);
            end
            checks++;
            if (res_tile !== e[19:16]) begin
                failures++; $display("FAIL res_tile: got %0d required %0d", res_tile, e[19:16]);
            end
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            checks++;
            if (res_valid !== 1'b0) begin
                failures++; $display("FAIL valid_drop: got %b required 0", res_valid);
            end
            if (t == nt - 1) begin
                checks++;
                if (job_done !== 1'b1) begin
                    failures++; $display("FAIL job_done_pulse: got %b required 1", job_done);
                end
                step();
                checks++;
                if (job_done !== 1'b0 || job_ready !== 1'b1) begin
                    failures++; $display("FAIL back_to_idle: done=%b ready=%b required 0 1", job_done, job_ready);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [38:0] exp_v;
        rst_n = 1'b0;
        step(); step();
        exp_v = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0};
        checks++;
        if ({job_ready, wmem_en, wmem_addr, rst_mvm, start_mvm, w_mvm, res_valid, res_data, res_tile, job_done, err} !== exp_v) begin
            failures++;
            $display("FAIL reset_outputs: got %h required %h",
                     {job_ready, wmem_en, wmem_addr, rst_mvm, start_mvm, w_mvm, res_valid, res_data, res_tile, job_done, err}, exp_v);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (job_ready !== 1'b1 || rst_mvm !== 1'b0) begin
            failures++; $display("FAIL reset_release: ready=%b rst_mvm=%b required 1 0", job_ready, rst_mvm);
        end
    endtask

    task automatic test_single_tile();
        int a0, s0, r0, bad;
        for (int a = 0; a < 256; a++) ram[a] = 4'h8;
        a0 = addr_log.size(); s0 = start_cnt; r0 = rst_cnt;
        issue_job(8'h10, 4'd1, 1'b1);
        drain_results(1, 0);
        bad = -1;
        for (int i = 0; i < W_CYCLES; i++)
            if (bad < 0 && (a0 + i >= addr_log.size() || addr_log[a0 + i] !== 8'(8'h10 + i))) bad = i;
        checks++;
        if (bad >= 0 || addr_log.size() - a0 != W_CYCLES) begin
            failures++; $display("FAIL single_addrs: reads=%0d first_bad=%0d required %0d contiguous from 10", addr_log.size() - a0, bad, W_CYCLES);
        end
        checks++;
        if (start_cnt - s0 != 1 || rst_cnt - r0 != 1) begin
            failures++; $display("FAIL single_pulses: start=%0d rst=%0d required 1 1", start_cnt - s0, rst_cnt - r0);
        end
    endtask

    task automatic test_three_tiles();
        int a0, s0, r0, bad;
        for (int a = 0; a < 256; a++) ram[a] = 4'(a * 7 + 3);
        a0 = addr_log.size(); s0 = start_cnt; r0 = rst_cnt;
        issue_job(8'h10, 4'd3, 1'b1);
        drain_results(3, 5);
        bad = -1;
        for (int i = 0; i < 3 * W_CYCLES; i++)
            if (bad < 0 && (a0 + i >= addr_log.size() || addr_log[a0 + i] !== 8'(8'h10 + i))) bad = i;
        checks++;
        if (bad >= 0 || addr_log.size() - a0 != 3 * W_CYCLES) begin
            failures++; $display("FAIL three_addrs: reads=%0d first_bad=%0d required 48 contiguous from 10", addr_log.size() - a0, bad);
        end
        checks++;
        if (start_cnt - s0 != 3 || rst_cnt - r0 != 3) begin
            failures++; $display("FAIL three_pulses: start=%0d rst=%0d required 3 3", start_cnt - s0, rst_cnt - r0);
        end
    endtask

    task automatic test_zero_tiles();
        int a0, s0, v0;
        a0 = addr_log.size(); s0 = start_cnt; v0 = valid_cnt;
        issue_job(8'h30, 4'd0, 1'b1);
        checks++;
        if (job_done !== 1'b1) begin
            failures++; $display("FAIL zero_done: got %b required 1", job_done);
        end
        step();
        checks++;
        if (job_done !== 1'b0 || job_ready !== 1'b1) begin
            failures++; $display("FAIL zero_idle: done=%b ready=%b required 0 1", job_done, job_ready);
        end
        checks++;
        if (addr_log.size() != a0 || start_cnt != s0 || valid_cnt != v0) begin
            failures++; $display("FAIL zero_activity: reads=%0d starts=%0d valids=%0d required 0 0 0",
                                 addr_log.size() - a0, start_cnt - s0, valid_cnt - v0);
        end
    endtask

    task automatic test_timeout();
        int v0;
        stuck = 1'b1;
        v0 = valid_cnt;
        issue_job(8'h50, 4'd1, 1'b0);
        repeat (W_CYCLES + TIMEOUT) step();
        checks++;
        if (err !== 1'b0 || job_done !== 1'b0) begin
            failures++; $display("FAIL timeout_early: err=%b done=%b required 0 0", err, job_done);
        end
        step();
        checks++;
        if (err !== 1'b1 || job_done !== 1'b1) begin
            failures++; $display("FAIL timeout_abort: err=%b done=%b required 1 1", err, job_done);
        end
        step();
        checks++;
        if (err !== 1'b1 || job_done !== 1'b0 || job_ready !== 1'b1 || valid_cnt != v0) begin
            failures++; $display("FAIL timeout_after: err=%b done=%b ready=%b valids=%0d required 1 0 1 0",
                                 err, job_done, job_ready, valid_cnt - v0);
        end
        stuck = 1'b0;
        issue_job(8'h20, 4'd1, 1'b1);
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL err_clear: got %b required 0", err);
        end
        drain_results(1, 2);
    endtask

    task automatic test_wrap();
        int a0, bad;
        a0 = addr_log.size();
        issue_job(8'hF8, 4'd1, 1'b1);
        drain_results(1, 0);
        bad = -1;
        for (int i = 0; i < W_CYCLES; i++)
            if (bad < 0 && (a0 + i >= addr_log.size() || addr_log[a0 + i] !== 8'(8'hF8 + i))) bad = i;
        checks++;
        if (bad >= 0 || addr_log.size() - a0 != W_CYCLES) begin
            failures++; $display("FAIL wrap_addrs: reads=%0d first_bad=%0d required 16 from F8 wrapping", addr_log.size() - a0, bad);
        end
    endtask

    task automatic test_reset_mid();
        logic [38:0] exp_v;
        int d0, v0;
        issue_job(8'h60, 4'd2, 1'b0);
        step();
        checks++;
        if (start_mvm !== 1'b1) begin
            failures++; $display("FAIL mid_start: got %b required 1", start_mvm);
        end
        repeat (5) step();
        d0 = done_cnt; v0 = valid_cnt;
        rst_n = 1'b0;
        step();
        exp_v = {1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0};
        checks++;
        if ({job_ready, wmem_en, wmem_addr, rst_mvm, start_mvm, w_mvm, res_valid, res_data, res_tile, job_done, err} !== exp_v) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h required %h",
                     {job_ready, wmem_en, wmem_addr, rst_mvm, start_mvm, w_mvm, res_valid, res_data, res_tile, job_done, err}, exp_v);
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (job_ready !== 1'b1 || done_cnt != d0 || valid_cnt != v0) begin
            failures++; $display("FAIL mid_reset_quiet: ready=%b dones=%0d valids=%0d required 1 0 0",
                                 job_ready, done_cnt - d0, valid_cnt - v0);
        end
        issue_job(8'h40, 4'd2, 1'b1);
        drain_results(2, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; job_wbase = 8'h00; job_tiles = 4'd0;
        res_ready = 1'b0; stuck = 1'b0;
        for (int a = 0; a < 256; a++) ram[a] = 4'h8;
        test_reset();
        test_single_tile();
        test_three_tiles();
        test_zero_tiles();
        test_timeout();
        test_wrap();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_empty: %0d left required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
